reorder_buffer: RTL and testbench

In-order retirement buffer that sits beside the rename stage and closes the physical-tag loop.
- At dispatch it records each renamed instruction's new physical tag and the tag it displaced.
- It marks entries complete from the functional-unit wakeup broadcast.
- It retires up to two entries per cycle, oldest first.
- On retirement it returns each displaced tag on freed_tag_1/freed_tag_2. The rename free pool consumes these; 0 means "nothing freed".

---
 rtl/reorder_buffer_pkg.sv | 32 +++
 rtl/reorder_buffer.sv | 143 ++++++++++++++
 tb/tb_reorder_buffer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: default geometry, entry field
// layout and the retire-width encoding.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH_DEF = 16;
  localparam int TAG_WIDTH_DEF = 6;
  localparam int ROB_IDX_W_DEF = $clog2(ROB_DEPTH_DEF);

  // Control word: the only per-entry state that reset has to clear.
  localparam int CTL_VALID    = 0;
  localparam int CTL_COMPLETE = 1;
  localparam int CTL_W        = 2;

  // Data word: {old_tag, tag, has_rd}, written only at dispatch.
  localparam int DAT_HAS_RD  = 0;
  localparam int DAT_TAG_LSB = 1;

  function automatic int dat_old_tag_lsb(input int tag_w);
    return DAT_TAG_LSB + tag_w;
  endfunction

  function automatic int dat_width(input int tag_w);
    return DAT_TAG_LSB + 2 * tag_w;
  endfunction

  typedef enum logic [1:0] {
    RET_NONE = 2'd0,
    RET_ONE  = 2'd1,
    RET_TWO  = 2'd2
  } retire_e;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: records renamed tags at dispatch, marks them
// complete on wakeup, retires up to two per cycle and returns displaced tags.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_DEPTH      = ROB_DEPTH_DEF,
  parameter int TAG_WIDTH      = TAG_WIDTH_DEF,
  parameter bit OVERFLOW_FATAL = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         dispatch_valid,
  input  logic                         dispatch_has_rd,
  input  logic [TAG_WIDTH-1:0]         dispatch_tag,
  input  logic [TAG_WIDTH-1:0]         dispatch_old_tag,
  output logic                         dispatch_ready,
  output logic [$clog2(ROB_DEPTH)-1:0] dispatch_index,
  input  logic                         wakeup_active,
  input  logic [TAG_WIDTH-1:0]         wakeup_tag,
  output logic [TAG_WIDTH-1:0]         freed_tag_1,
  output logic [TAG_WIDTH-1:0]         freed_tag_2,
  output logic [1:0]                   retire_count,
  output logic [$clog2(ROB_DEPTH):0]   count,
  output logic                         empty
);

  localparam int IDX_W   = $clog2(ROB_DEPTH);
  localparam int CNT_W   = IDX_W + 1;
  localparam int OLD_LSB = dat_old_tag_lsb(TAG_WIDTH);
  localparam int DAT_W   = dat_width(TAG_WIDTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROB_DEPTH);

  logic [CTL_W-1:0]     ctl_q [ROB_DEPTH];
  logic [DAT_W-1:0]     dat_q [ROB_DEPTH];
  logic [IDX_W-1:0]     head_q;
  logic [IDX_W-1:0]     tail_q;
  logic [CNT_W-1:0]     occ_q;

  logic [IDX_W-1:0]     head_nxt1;
  logic                 accept;
  logic                 ret_old;
  logic                 ret_young;
  retire_e              ret_sel;
  logic [1:0]           ret_cnt;
  logic [DAT_W-1:0]     dat_in;
  logic [ROB_DEPTH-1:0] wake_hit;

  function automatic retire_e retire_pick(input logic old_ok, input logic young_ok);
    if (old_ok && young_ok) return RET_TWO;
    if (old_ok)             return RET_ONE;
    return RET_NONE;
  endfunction

  // Tag 0 is never handed back, whether by has_rd=0 or by an old_tag of 0.
  function automatic logic [TAG_WIDTH-1:0] freed_of(input logic ret, input logic [DAT_W-1:0] d);
    if (ret && d[DAT_HAS_RD]) return d[OLD_LSB +: TAG_WIDTH];
    return '0;
  endfunction

  always_comb begin
    head_nxt1 = head_q + IDX_W'(1);
    accept    = dispatch_valid && (occ_q < FULL_CNT);
    ret_old   = ctl_q[head_q][CTL_VALID] && ctl_q[head_q][CTL_COMPLETE];
    ret_young = ret_old && ctl_q[head_nxt1][CTL_VALID] && ctl_q[head_nxt1][CTL_COMPLETE];
    ret_sel   = retire_pick(ret_old, ret_young);
    ret_cnt   = ret_sel;

    dat_in                         = '0;
    dat_in[DAT_HAS_RD]             = dispatch_has_rd;
    dat_in[DAT_TAG_LSB +: TAG_WIDTH] = dispatch_tag;
    dat_in[OLD_LSB +: TAG_WIDTH]   = dispatch_old_tag;
  end

  always_comb begin
    wake_hit = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      wake_hit[i] = wakeup_active && (wakeup_tag != '0) && ctl_q[i][CTL_VALID] &&
                    dat_q[i][DAT_HAS_RD] && (dat_q[i][DAT_TAG_LSB +: TAG_WIDTH] == wakeup_tag);
    end
  end

  // Per-entry control: retire clears first, dispatch writes last so a freshly
  // allocated entry never picks up this cycle's wakeup.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) ctl_q[i] <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (wake_hit[i]) ctl_q[i][CTL_COMPLETE] <= 1'b1;
      end
      if (ret_old)   ctl_q[head_q]    <= '0;
      if (ret_young) ctl_q[head_nxt1] <= '0;
      if (accept) begin
        ctl_q[tail_q][CTL_VALID]    <= 1'b1;
        ctl_q[tail_q][CTL_COMPLETE] <= !dispatch_has_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) dat_q[tail_q] <= dat_in;
  end

  // Pointers, occupancy and the registered retire report.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      occ_q        <= '0;
      freed_tag_1  <= '0;
      freed_tag_2  <= '0;
      retire_count <= '0;
    end else begin
      head_q       <= head_q + IDX_W'(ret_cnt);
      if (accept) tail_q <= tail_q + IDX_W'(1);
      occ_q        <= occ_q + CNT_W'(accept) - CNT_W'(ret_cnt);
      freed_tag_1  <= freed_of(ret_old, dat_q[head_q]);
      freed_tag_2  <= freed_of(ret_young, dat_q[head_nxt1]);
      retire_count <= ret_cnt;
    end
  end

  assign dispatch_ready = (occ_q < FULL_CNT);
  assign dispatch_index = tail_q;
  assign count          = occ_q;
  assign empty          = (occ_q == '0);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (OVERFLOW_FATAL && dispatch_valid && !dispatch_ready)
        $fatal(1, "reorder_buffer: dispatch while full");
      if (dispatch_valid && dispatch_has_rd && (dispatch_tag == '0))
        $fatal(1, "reorder_buffer: dispatch with has_rd and tag 0");
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (wake_hit[i] && ctl_q[i][CTL_COMPLETE])
          $fatal(1, "reorder_buffer: double wakeup on entry %0d", i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;

  logic       clk;
  logic       reset_n;
  logic       dispatch_valid;
  logic       dispatch_has_rd;
  logic [5:0] dispatch_tag;
  logic [5:0] dispatch_old_tag;
  logic       dispatch_ready;
  logic [3:0] dispatch_index;
  logic       wakeup_active;
  logic [5:0] wakeup_tag;
  logic [5:0] freed_tag_1;
  logic [5:0] freed_tag_2;
  logic [1:0] retire_count;
  logic [4:0] count;
  logic       empty;

  int n_chk;
  int n_fail;
  int freed_sum;
  int ret_sum;

  reorder_buffer #(
    .ROB_DEPTH     (16),
    .TAG_WIDTH     (6),
    .OVERFLOW_FATAL(1'b0)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .dispatch_valid  (dispatch_valid),
    .dispatch_has_rd (dispatch_has_rd),
    .dispatch_tag    (dispatch_tag),
    .dispatch_old_tag(dispatch_old_tag),
    .dispatch_ready  (dispatch_ready),
    .dispatch_index  (dispatch_index),
    .wakeup_active   (wakeup_active),
    .wakeup_tag      (wakeup_tag),
    .freed_tag_1     (freed_tag_1),
    .freed_tag_2     (freed_tag_2),
    .retire_count    (retire_count),
    .count           (count),
    .empty           (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then return 1 time unit after the edge.
  task automatic cyc(input logic dv, input logic hr, input logic [5:0] t, input logic [5:0] o,
                     input logic wa, input logic [5:0] wt);
    dispatch_valid   = dv;
    dispatch_has_rd  = hr;
    dispatch_tag     = t;
    dispatch_old_tag = o;
    wakeup_active    = wa;
    wakeup_tag       = wt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_empty"}, 32'(empty), 32'd1);
    check_val({pfx, "_ready"}, 32'(dispatch_ready), 32'd1);
    check_val({pfx, "_count"}, 32'(count), 32'd0);
    check_val({pfx, "_index"}, 32'(dispatch_index), 32'd0);
    check_val({pfx, "_freed1"}, 32'(freed_tag_1), 32'd0);
    check_val({pfx, "_freed2"}, 32'(freed_tag_2), 32'd0);
    check_val({pfx, "_retcnt"}, 32'(retire_count), 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b0;
    dispatch_valid = 1'b0;
    dispatch_has_rd = 1'b0;
    dispatch_tag = '0;
    dispatch_old_tag = '0;
    wakeup_active = 1'b0;
    wakeup_tag = '0;

    // 1: reset
    #1;
    check_reset_outputs("rst_hold");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_reset_outputs("rst_rel");

    // 2: single dispatch, wakeup, retire
    cyc(1'b1, 1'b1, 6'd32, 6'd5, 1'b0, 6'd0);
    check_val("t2_count_disp", 32'(count), 32'd1);
    check_val("t2_empty_disp", 32'(empty), 32'd0);
    cyc(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd32);
    check_val("t2_no_early_ret", 32'(retire_count), 32'd0);
    idle();
    check_val("t2_freed1", 32'(freed_tag_1), 32'd5);
    check_val("t2_freed2", 32'(freed_tag_2), 32'd0);
    check_val("t2_retcnt", 32'(retire_count), 32'd1);
    check_val("t2_empty", 32'(empty), 32'd1);
    idle();
    check_val("t2_freed1_clr", 32'(freed_tag_1), 32'd0);
    check_val("t2_retcnt_clr", 32'(retire_count), 32'd0);

    // 3: younger completes first, both retire together
    cyc(1'b1, 1'b1, 6'd33, 6'd1, 1'b0, 6'd0);
    cyc(1'b1, 1'b1, 6'd34, 6'd2, 1'b0, 6'd0);
    cyc(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd34);
    check_val("t3_blocked_ret", 32'(retire_count), 32'd0);
    check_val("t3_count2", 32'(count), 32'd2);
    cyc(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd33);
    check_val("t3_blocked_ret2", 32'(retire_count), 32'd0);
    idle();
    check_val("t3_freed1", 32'(freed_tag_1), 32'd1);
    check_val("t3_freed2", 32'(freed_tag_2), 32'd2);
    check_val("t3_retcnt", 32'(retire_count), 32'd2);
    check_val("t3_count0", 32'(count), 32'd0);

    // 4: fill to 16 (head = tail = 3), drop the 17th, retire one, then drain
    check_val("t4_index_start", 32'(dispatch_index), 32'd3);
    for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 6'(40 + k), 6'(10 + k), 1'b0, 6'd0);
    check_val("t4_count_full", 32'(count), 32'd16);
    check_val("t4_ready_full", 32'(dispatch_ready), 32'd0);
    check_val("t4_index_full", 32'(dispatch_index), 32'd3);
    cyc(1'b1, 1'b1, 6'd60, 6'd30, 1'b0, 6'd0);
    check_val("t4_count_drop", 32'(count), 32'd16);
    check_val("t4_index_drop", 32'(dispatch_index), 32'd3);
    cyc(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd40);
    idle();
    check_val("t4_freed1", 32'(freed_tag_1), 32'd10);
    check_val("t4_retcnt", 32'(retire_count), 32'd1);
    check_val("t4_count15", 32'(count), 32'd15);
    check_val("t4_ready", 32'(dispatch_ready), 32'd1);
    freed_sum = 0;
    ret_sum = 0;
    for (int k = 1; k < 16; k++) begin
      cyc(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 6'(40 + k));
      freed_sum += int'(freed_tag_1) + int'(freed_tag_2);
      ret_sum += int'(retire_count);
    end
    repeat (2) begin
      idle();
      freed_sum += int'(freed_tag_1) + int'(freed_tag_2);
      ret_sum += int'(retire_count);
    end
    check_val("t4_drain_freed_sum", 32'(freed_sum), 32'd270);
    check_val("t4_drain_ret_sum", 32'(ret_sum), 32'd15);
    check_val("t4_drain_empty", 32'(empty), 32'd1);

    // 5: has_rd=0 retires next edge; has_rd=1 with old_tag 0 frees nothing
    cyc(1'b1, 1'b0, 6'd0, 6'd7, 1'b0, 6'd0);
    check_val("t5_nord_pending", 32'(retire_count), 32'd0);
    cyc(1'b1, 1'b1, 6'd61, 6'd0, 1'b0, 6'd0);
    check_val("t5_nord_retcnt", 32'(retire_count), 32'd1);
    check_val("t5_nord_freed1", 32'(freed_tag_1), 32'd0);
    check_val("t5_count1", 32'(count), 32'd1);
    cyc(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd61);
    check_val("t5_wake_retcnt", 32'(retire_count), 32'd0);
    idle();
    check_val("t5_old0_retcnt", 32'(retire_count), 32'd1);
    check_val("t5_old0_freed1", 32'(freed_tag_1), 32'd0);
    check_val("t5_count0", 32'(count), 32'd0);

    // 6: walk head to 14, put 5 in flight across the wrap, reset mid-cycle
    for (int k = 0; k < 9; k++) cyc(1'b1, 1'b0, 6'd0, 6'd9, 1'b0, 6'd0);
    idle();
    check_val("t6_head14_index", 32'(dispatch_index), 32'd14);
    check_val("t6_head14_count", 32'(count), 32'd0);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 6'(20 + k), 6'(1 + k), 1'b0, 6'd0);
    check_val("t6_count5", 32'(count), 32'd5);
    check_val("t6_index_wrap", 32'(dispatch_index), 32'd3);
    cyc(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd20);
    wakeup_active = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 6'd22);
    check_val("t6_post_retcnt", 32'(retire_count), 32'd0);
    idle();
    check_val("t6_post2_freed1", 32'(freed_tag_1), 32'd0);
    check_val("t6_post2_retcnt", 32'(retire_count), 32'd0);
    check_val("t6_post2_count", 32'(count), 32'd0);
    idle();
    check_val("t6_post3_freed1", 32'(freed_tag_1), 32'd0);
    check_val("t6_post3_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
